// File: rtl/ddr_access_arbiter_pkg.sv
// ddr_access_arbiter_pkg: DDR command codes and arbiter FSM states shared by the arbiter files
package ddr_access_arbiter_pkg;
  localparam logic [3:0] CMD_NOP   = 4'h0;
  localparam logic [3:0] CMD_READ  = 4'h1;
  localparam logic [3:0] CMD_WRITE = 4'h2;
  typedef enum logic [1:0] {S_INIT, S_ARB, S_ISSUE, S_WAIT} state_e;
endpackage

// File: rtl/ddr_access_arbiter_tag_fifo.sv
// ddr_access_arbiter_tag_fifo: synchronous FIFO of requester indices for reads still in flight
module ddr_access_arbiter_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign dout = mem_q[rp_q];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wp_q] <= din;
        wp_q <= wp_q + 1'b1;
      end
      if (do_pop) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/ddr_access_arbiter.sv
// ddr_access_arbiter: shares the DDR controller command port among requesters and steers read returns
module ddr_access_arbiter
  import ddr_access_arbiter_pkg::*;
#(
  parameter int NREQ = 5,
  parameter int ADDR_W = 25,
  parameter int DATA_W = 128,
  parameter logic [NREQ-1:0] HIPRI_MASK = NREQ'(1),
  parameter int TAG_DEPTH = 4,
  parameter int MAX_WAIT = 64
) (
  input  logic                   clk_133M,
  input  logic                   rst_133M,
  input  logic                   init_done,
  input  logic                   cmd_busy,
  input  logic                   ddr_data_valid,
  input  logic [DATA_W-1:0]      ddr_rd_data,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_is_wr,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        req_grant,
  output logic [NREQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]      rd_data,
  output logic [3:0]             cmd,
  output logic                   cmd_valid,
  output logic [ADDR_W-1:0]      ddr_address,
  output logic [DATA_W-1:0]      ddr_wr_data,
  output logic                   busy
);
  localparam int TW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_WAIT + 1);
  state_e state_q;
  logic [NREQ-1:0] elig, starved, hp, rr_elig;
  logic [TW-1:0] win, win_q, rr_q, rr_nxt, tag;
  logic [CW-1:0] cnt_q [NREQ];
  logic [1:0] tmo_q;
  logic any, wr_q, seen_q, full, empty, push, pop;
  // Reads are only eligible while a tag slot is free; writes never need one.
  always_comb begin : sel
    int j;
    logic found;
    j = 0;
    found = 1'b0;
    elig = req_valid & (req_is_wr | {NREQ{~full}});
    any = |elig;
    for (int i = 0; i < NREQ; i++) starved[i] = elig[i] && cnt_q[i] == CW'(MAX_WAIT);
    hp = elig & HIPRI_MASK;
    rr_elig = elig & ~HIPRI_MASK;
    win = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_q) + k;
      j = j >= NREQ ? j - NREQ : j;
      if (!found && rr_elig[j]) begin
        win = TW'(j);
        found = 1'b1;
      end
    end
    for (int i = NREQ - 1; i >= 0; i--) if (hp[i]) win = TW'(i);
    for (int i = NREQ - 1; i >= 0; i--) if (starved[i]) win = TW'(i);
    rr_nxt = rr_q;
    for (int k = NREQ - 1; k >= 1; k--) begin
      j = int'(win) + k;
      j = j >= NREQ ? j - NREQ : j;
      if (!HIPRI_MASK[j]) rr_nxt = TW'(j);
    end
  end
  always_ff @(posedge clk_133M)
    for (int i = 0; i < NREQ; i++)
      if (rst_133M || req_grant[i]) cnt_q[i] <= '0;
      else if (req_valid[i] && cnt_q[i] != CW'(MAX_WAIT)) cnt_q[i] <= cnt_q[i] + 1'b1;
  always_ff @(posedge clk_133M) begin
    if (rst_133M) begin
      state_q <= S_INIT;
      rr_q <= TW'(1);
      win_q <= '0;
      wr_q <= 1'b0;
      seen_q <= 1'b0;
      tmo_q <= '0;
      req_grant <= '0;
      cmd <= CMD_NOP;
      cmd_valid <= 1'b0;
      ddr_address <= '0;
      ddr_wr_data <= '0;
      busy <= 1'b0;
    end else begin
      req_grant <= '0;
      cmd_valid <= 1'b0;
      cmd <= CMD_NOP;
      case (state_q)
        S_INIT: state_q <= init_done ? S_ARB : S_INIT;
        S_ARB:
          if (!init_done) state_q <= S_INIT;
          else if (any) begin
            req_grant <= NREQ'(1) << win;
            ddr_address <= req_addr[win*ADDR_W +: ADDR_W];
            ddr_wr_data <= req_wdata[win*DATA_W +: DATA_W];
            wr_q <= req_is_wr[win];
            win_q <= win;
            rr_q <= rr_nxt;
            busy <= 1'b1;
            state_q <= S_ISSUE;
          end
        S_ISSUE:
          if (!cmd_busy) begin
            cmd_valid <= 1'b1;
            cmd <= wr_q ? CMD_WRITE : CMD_READ;
            seen_q <= 1'b0;
            tmo_q <= '0;
            state_q <= S_WAIT;
          end
        S_WAIT: begin
          // A controller that never raises busy must not hang the port.
          seen_q <= seen_q | cmd_busy;
          tmo_q <= tmo_q + 2'(tmo_q != 2'd3);
          if (!cmd_busy && (seen_q || tmo_q == 2'd3)) begin
            busy <= 1'b0;
            state_q <= init_done ? S_ARB : S_INIT;
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end
  assign push = state_q == S_ISSUE && !cmd_busy && !wr_q;
  assign pop = ddr_data_valid && !empty;
  ddr_access_arbiter_tag_fifo #(.DEPTH(TAG_DEPTH), .W(TW)) u_tags (
    .clk  (clk_133M),
    .rst  (rst_133M),
    .push (push),
    .pop  (pop),
    .din  (win_q),
    .dout (tag),
    .full (full),
    .empty(empty)
  );
  always_ff @(posedge clk_133M) begin
    rd_valid <= (rst_133M || !pop) ? '0 : NREQ'(1) << tag;
    rd_data <= rst_133M ? '0 : (ddr_data_valid ? ddr_rd_data : rd_data);
  end
endmodule

// File: tb/tb_ddr_access_arbiter.sv
// tb_ddr_access_arbiter: directed vectors with a small DDR controller model and read-return scoreboard
module tb_ddr_access_arbiter;
  import ddr_access_arbiter_pkg::*;
  localparam int N = 5, AW = 25, DW = 128;
  logic clk_133M = 1'b0;
  logic rst_133M, init_done, cmd_busy, ddr_data_valid;
  logic [DW-1:0] ddr_rd_data, rd_data, ddr_wr_data;
  logic [N-1:0] req_valid, req_is_wr, req_grant, rd_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [3:0] cmd;
  logic cmd_valid, busy;
  logic [AW-1:0] ddr_address;
  int total = 0, bad = 0;
  int cyc = 0, bl = 0, ncmd = 0, exp_t = 0;
  int gcnt[N];
  int gseq[$], tagq[$];
  logic [N-1:0] rvseq[$];
  logic [DW-1:0] rq[$];
  logic [N-1:0] oneshot;
  logic auto_rd, force_dv, exp_rv, exp_wr;
  logic [AW-1:0] exp_a;
  logic [DW-1:0] exp_d, exp_w;

  ddr_access_arbiter dut (
    .clk_133M(clk_133M), .rst_133M(rst_133M), .init_done(init_done), .cmd_busy(cmd_busy),
    .ddr_data_valid(ddr_data_valid), .ddr_rd_data(ddr_rd_data), .req_valid(req_valid),
    .req_is_wr(req_is_wr), .req_addr(req_addr), .req_wdata(req_wdata), .req_grant(req_grant),
    .rd_valid(rd_valid), .rd_data(rd_data), .cmd(cmd), .cmd_valid(cmd_valid),
    .ddr_address(ddr_address), .ddr_wr_data(ddr_wr_data), .busy(busy)
  );

  always #5 clk_133M = ~clk_133M;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    int g;
    logic [N-1:0] erv;
    @(negedge clk_133M);
    cyc++;
    erv = exp_rv ? N'(1) << exp_t : '0;
    chk("rd_valid", rd_valid, erv);
    if (exp_rv) chk("rd_data", rd_data, exp_d);
    exp_rv = 1'b0;
    if (rd_valid != '0) rvseq.push_back(rd_valid);
    if (req_grant != '0) begin
      g = 0;
      for (int i = 0; i < N; i++) if (req_grant[i]) g = i;
      chk("grant_onehot", $onehot(req_grant), 1);
      chk("busy_at_grant", busy, 1);
      gseq.push_back(g);
      gcnt[g]++;
      exp_wr = req_is_wr[g];
      exp_a = req_addr[g*AW +: AW];
      exp_w = req_wdata[g*DW +: DW];
      if (!exp_wr) tagq.push_back(g);
      if (oneshot[g]) req_valid[g] = 1'b0;
    end
    if (cmd_valid) begin
      ncmd++;
      chk("cmd", cmd, exp_wr ? CMD_WRITE : CMD_READ);
      chk("cmd_addr", ddr_address, exp_a);
      if (exp_wr) chk("cmd_wdata", ddr_wr_data, exp_w);
      else rq.push_back({4{7'h0, exp_a}});
      bl = 2;
    end
    cmd_busy = bl > 0;
    if (bl > 0) bl--;
    ddr_data_valid = 1'b0;
    if (force_dv || (auto_rd && rq.size() > 0)) begin
      ddr_data_valid = 1'b1;
      ddr_rd_data = rq.size() > 0 ? rq.pop_front() : {4{32'hDEADBEEF}};
      if (tagq.size() > 0) begin
        exp_rv = 1'b1;
        exp_t = tagq.pop_front();
        exp_d = ddr_rd_data;
      end
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_grant(input string tag, input int lim);
    int n;
    n = gseq.size();
    for (int i = 0; i < lim && gseq.size() == n; i++) step();
    chk(tag, gseq.size() > n, 1);
  endtask

  task automatic ret();
    force_dv = 1'b1;
    step();
    force_dv = 1'b0;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic one);
    req_is_wr[i] = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    oneshot[i] = one;
    req_valid[i] = 1'b1;
  endtask

  initial begin
    int base, c0, g0, h2;
    rst_133M = 1'b1; init_done = 1'b0; cmd_busy = 1'b0; ddr_data_valid = 1'b0; ddr_rd_data = '0;
    req_valid = '0; req_is_wr = '0; req_addr = '0; req_wdata = '0; oneshot = '0;
    auto_rd = 1'b1; force_dv = 1'b0; exp_rv = 1'b0; exp_wr = 1'b0; exp_a = '0; exp_d = '0; exp_w = '0;
    for (int i = 0; i < N; i++) gcnt[i] = 0;
    steps(2);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", req_grant, 0);
    chk("rst_cmd", cmd, CMD_NOP);
    chk("rst_addr", ddr_address, 0);
    chk("rst_rd_valid", rd_valid, 0);
    rst_133M = 1'b0;
    // 1: nothing before init_done, then VGA first
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(32'h100 * i), '0, 1'b0);
    steps(6);
    chk("t1_no_grant", gseq.size(), 0);
    chk("t1_no_cmd", ncmd, 0);
    init_done = 1'b1;
    wait_grant("t1_grant_seen", 10);
    req_valid = '0;
    chk("t1_first_vga", gseq[0], 0);
    steps(8);
    // 2: round-robin among writers 1,3,4
    base = gseq.size();
    set_req(1, 1'b1, 25'h0100001, {4{32'hC0DE0001}}, 1'b0);
    set_req(3, 1'b1, 25'h0100003, {4{32'hC0DE0003}}, 1'b0);
    set_req(4, 1'b1, 25'h0100004, {4{32'hC0DE0004}}, 1'b0);
    for (int k = 0; k < 6; k++) wait_grant("t2_grant_seen", 20);
    req_valid = '0;
    chk("t2_g0", gseq[base], 1);
    chk("t2_g1", gseq[base+1], 3);
    chk("t2_g2", gseq[base+2], 4);
    chk("t2_g3", gseq[base+3], 1);
    chk("t2_g4", gseq[base+4], 3);
    chk("t2_g5", gseq[base+5], 4);
    steps(8);
    // 3: VGA streaming reads, UART breaks in after 64 cycles of waiting
    g0 = gcnt[0];
    h2 = gcnt[4];
    c0 = cyc;
    set_req(0, 1'b0, 25'h0001000, '0, 1'b0);
    set_req(4, 1'b0, 25'h0002000, '0, 1'b1);
    for (int i = 0; i < 120 && gcnt[4] == h2; i++) step();
    chk("t3_uart_granted", gcnt[4] - h2, 1);
    chk("t3_in_window", (cyc - c0) >= 64 && (cyc - c0) <= 72, 1);
    chk("t3_vga_served", (gcnt[0] - g0) >= 10, 1);
    req_valid = '0;
    steps(10);
    // 4: reads 2,0,2 returned in order
    auto_rd = 1'b0;
    set_req(2, 1'b0, 25'h0000222, '0, 1'b1);
    wait_grant("t4_gA", 20);
    set_req(0, 1'b0, 25'h0000333, '0, 1'b1);
    wait_grant("t4_gB", 20);
    set_req(2, 1'b0, 25'h0000444, '0, 1'b1);
    wait_grant("t4_gC", 20);
    steps(6);
    rvseq.delete();
    ret(); step(); ret(); step(); ret(); steps(2);
    chk("t4_nret", rvseq.size(), 3);
    chk("t4_rv0", rvseq[0], 5'b00100);
    chk("t4_rv1", rvseq[1], 5'b00001);
    chk("t4_rv2", rvseq[2], 5'b00100);
    // 5: tag FIFO full blocks reads but not writes
    set_req(1, 1'b0, 25'h0000501, '0, 1'b1); wait_grant("t5_r1", 20);
    set_req(2, 1'b0, 25'h0000502, '0, 1'b1); wait_grant("t5_r2", 20);
    set_req(4, 1'b0, 25'h0000504, '0, 1'b1); wait_grant("t5_r4", 20);
    set_req(0, 1'b0, 25'h0000500, '0, 1'b1); wait_grant("t5_r0", 20);
    steps(6);
    chk("t5_outstanding", rq.size(), 4);
    h2 = gcnt[2];
    set_req(2, 1'b0, 25'h0000602, '0, 1'b1);
    set_req(3, 1'b1, 25'h0000603, {4{32'h5EED0003}}, 1'b1);
    wait_grant("t5_gw", 20);
    chk("t5_write_first", gseq[gseq.size()-1], 3);
    steps(20);
    chk("t5_read_held", gcnt[2] - h2, 0);
    ret();
    wait_grant("t5_gr", 20);
    chk("t5_read_after_ret", gseq[gseq.size()-1], 2);
    steps(6);
    for (int k = 0; k < 4; k++) begin ret(); step(); end
    steps(2);
    chk("t5_drained", rq.size(), 0);
    // 6: reset while waiting with two reads in flight
    set_req(1, 1'b0, 25'h0000701, '0, 1'b1); wait_grant("t6_gA", 20);
    steps(6);
    set_req(4, 1'b0, 25'h0000704, '0, 1'b1); wait_grant("t6_gB", 20);
    step();
    chk("t6_pre_outstanding", rq.size(), 2);
    chk("t6_pre_busy", busy, 1);
    rst_133M = 1'b1;
    step();
    chk("t6_busy", busy, 0);
    chk("t6_cmd_valid", cmd_valid, 0);
    chk("t6_grant", req_grant, 0);
    chk("t6_cmd", cmd, CMD_NOP);
    chk("t6_addr", ddr_address, 0);
    chk("t6_rd_valid", rd_valid, 0);
    tagq.delete(); rq.delete(); bl = 0; cmd_busy = 1'b0; req_valid = '0;
    rst_133M = 1'b0;
    rvseq.delete();
    step(); ret(); steps(3);
    chk("t6_stray_ignored", rvseq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
